// File: rtl/pcg_stream_gen_if.sv
// Handshake bundle for pcg_stream_gen: generator controls in, random words out
// under valid/ready.
interface pcg_stream_gen_if #(
   parameter int STATE_W = 16,
   parameter int OUT_W   = 8
);
   logic               enable;
   logic [STATE_W-2:0] stream;
   logic               seed_valid;
   logic [STATE_W-1:0] seed;
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   out_data;

   modport master (
      output enable, stream, seed_valid, seed, out_ready,
      input  out_valid, out_data
   );

   modport slave (
      input  enable, stream, seed_valid, seed, out_ready,
      output out_valid, out_data
   );
endinterface

// File: rtl/pcg_stream_gen.sv
// Parametrised PCG XSH-RR generator: LCG state, xorshift stage and rotate stage,
// all advancing together under a valid/ready output handshake.
module pcg_stream_gen #(
   parameter int                 STATE_W    = 16,
   parameter int                 OUT_W      = 8,
   parameter logic [STATE_W-1:0] MULT       = STATE_W'(16'h5851),
   parameter logic [STATE_W-1:0] RESET_SEED = '0
) (
   input  logic             clk,
   input  logic             rst,
   pcg_stream_gen_if.slave  bus
);

   localparam int ROT_W = $clog2(OUT_W);
   localparam int XS    = (OUT_W + ROT_W) / 2;
   localparam int SH    = STATE_W - OUT_W - ROT_W;

   function automatic logic [STATE_W-1:0] lcg_next(input logic [STATE_W-1:0] s,
                                                   input logic [STATE_W-1:0] inc);
      return s * MULT + inc;
   endfunction

   // Rotate via a doubled word so a zero rotation never needs a shift by OUT_W.
   function automatic logic [OUT_W-1:0] rotr(input logic [OUT_W-1:0] x,
                                             input logic [ROT_W-1:0] r);
      return OUT_W'({x, x} >> r);
   endfunction

   logic [STATE_W-1:0] state_p0_q, state_p0_d;
   logic [OUT_W-1:0]   xs_p1_q, xs_p1_d;
   logic [ROT_W-1:0]   rot_p1_q, rot_p1_d;
   logic               vld_p1_q, vld_p1_d;
   logic [OUT_W-1:0]   data_p2_q, data_p2_d;
   logic               vld_p2_q, vld_p2_d;
   logic               adv;
   logic [STATE_W-1:0] inc;

   always_comb begin
      adv        = ~vld_p2_q | bus.out_ready;
      inc        = {bus.stream, 1'b1};
      state_p0_d = state_p0_q;
      xs_p1_d    = xs_p1_q;
      rot_p1_d   = rot_p1_q;
      vld_p1_d   = vld_p1_q;
      data_p2_d  = data_p2_q;
      vld_p2_d   = vld_p2_q;

      // p0: LCG state; a seed load wins over a normal advance
      if (bus.seed_valid) begin
         state_p0_d = bus.seed;
      end else if (bus.enable && adv) begin
         state_p0_d = lcg_next(state_p0_q, inc);
      end

      // p1: xorshift of the pre-update state; a seed discards the word here
      if (adv) begin
         xs_p1_d  = OUT_W'(((state_p0_q >> XS) ^ state_p0_q) >> SH);
         rot_p1_d = state_p0_q[STATE_W-1 -: ROT_W];
      end
      if (bus.seed_valid) begin
         vld_p1_d = 1'b0;
      end else if (adv) begin
         vld_p1_d = bus.enable;
      end

      // p2: rotate; a stalled word survives a seed until it is accepted
      if (adv) begin
         data_p2_d = rotr(xs_p1_q, rot_p1_q);
         vld_p2_d  = vld_p1_q & ~bus.seed_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0_q <= RESET_SEED;
         xs_p1_q    <= '0;
         rot_p1_q   <= '0;
         vld_p1_q   <= 1'b0;
         data_p2_q  <= '0;
         vld_p2_q   <= 1'b0;
      end else begin
         state_p0_q <= state_p0_d;
         xs_p1_q    <= xs_p1_d;
         rot_p1_q   <= rot_p1_d;
         vld_p1_q   <= vld_p1_d;
         data_p2_q  <= data_p2_d;
         vld_p2_q   <= vld_p2_d;
      end
   end

   assign bus.out_valid = vld_p2_q;
   assign bus.out_data  = data_p2_q;

endmodule

// File: tb/tb_pcg_stream_gen.sv
// Bench for pcg_stream_gen: 16/8 instance against hand-derived vectors and a
// scoreboard, 64/32 instance against a pcg32 reference model.
module tb_pcg_stream_gen;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pcg_stream_gen_if #(.STATE_W(16), .OUT_W(8))  b8  ();
   pcg_stream_gen_if #(.STATE_W(64), .OUT_W(32)) b32 ();

   pcg_stream_gen #(.STATE_W(16), .OUT_W(8), .MULT(16'h5851), .RESET_SEED(16'h0000))
      u8 (.clk(clk), .rst(rst), .bus(b8));

   pcg_stream_gen #(.STATE_W(64), .OUT_W(32), .MULT(64'h5851F42D4C957F2D),
                    .RESET_SEED(64'h0))
      u32 (.clk(clk), .rst(rst), .bus(b32));

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] seed;
      logic [14:0] strm;
      logic [7:0]  w0;
      logic [7:0]  w1;
      logic [7:0]  w2;
   } vec_t;

   logic [7:0]  q8[$];
   logic [31:0] q32[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [7:0] ref8(input logic [15:0] s);
      logic [7:0] x;
      int         r;
      x = 8'(((s >> 5) ^ s) >> 5);
      r = int'(s[15:13]);
      return (x >> r) | (x << ((8 - r) & 7));
   endfunction

   function automatic logic [31:0] ref32(input logic [63:0] s);
      logic [31:0] x;
      int          r;
      x = 32'(((s >> 18) ^ s) >> 27);
      r = int'(s[63:59]);
      return (x >> r) | (x << ((32 - r) & 31));
   endfunction

   task automatic fill8(input logic [15:0] seed, input logic [15:0] inc, input int n);
      logic [15:0] s;
      s = seed;
      q8.delete();
      for (int i = 0; i < n; i++) begin
         q8.push_back(ref8(s));
         s = s * 16'h5851 + inc;
      end
   endtask

   task automatic fill32(input logic [63:0] seed, input logic [63:0] inc, input int n);
      logic [63:0] s;
      s = seed;
      q32.delete();
      for (int i = 0; i < n; i++) begin
         q32.push_back(ref32(s));
         s = s * 64'h5851F42D4C957F2D + inc;
      end
   endtask

   // Seed load with out_ready high: two idle cycles, then the three listed words.
   task automatic apply_vec(input vec_t v);
      logic [7:0] w[3];
      w[0] = v.w0; w[1] = v.w1; w[2] = v.w2;
      b8.seed = v.seed; b8.stream = v.strm;
      b8.seed_valid = 1'b1; b8.enable = 1'b1; b8.out_ready = 1'b1;
      tick();
      b8.seed_valid = 1'b0;
      check("seed_flush_c1", 64'(b8.out_valid), 64'd0);
      tick();
      check("seed_flush_c2", 64'(b8.out_valid), 64'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("vec_valid", 64'(b8.out_valid), 64'd1);
         check("vec_word", 64'(b8.out_data), 64'(w[k]));
         tick();
      end
   endtask

   task automatic run8(input int n, input int stall_from, input int stall_len);
      int         got;
      logic       stalled;
      logic [7:0] held;
      logic [7:0] exp;
      got = 0; stalled = 1'b0; held = '0;
      for (int c = 0; c < 200 && got < n; c++) begin
         b8.out_ready = (c >= stall_from && c < stall_from + stall_len) ? 1'b0 : 1'b1;
         if (stalled) begin
            check("stall_valid", 64'(b8.out_valid), 64'd1);
            check("stall_data", 64'(b8.out_data), 64'(held));
         end
         if (b8.out_valid && b8.out_ready) begin
            exp = (q8.size() > 0) ? q8.pop_front() : 8'hxx;
            check("sb8_word", 64'(b8.out_data), 64'(exp));
            got++;
         end
         stalled = b8.out_valid & ~b8.out_ready;
         held    = b8.out_data;
         tick();
      end
      check("sb8_count", 64'(got), 64'(n));
   endtask

   task automatic run32(input int n, input bit rnd);
      int          got;
      logic [31:0] exp;
      got = 0;
      for (int c = 0; c < 4 * n + 20 && got < n; c++) begin
         b32.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (b32.out_valid && b32.out_ready) begin
            exp = (q32.size() > 0) ? q32.pop_front() : 32'hxxxxxxxx;
            check("pcg32_word", 64'(b32.out_data), 64'(exp));
            got++;
         end
         tick();
      end
      check("pcg32_count", 64'(got), 64'(n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[4];
      vt[0] = '{seed: 16'h0000, strm: 15'd0, w0: 8'h00, w1: 8'h00, w2: 8'h35};
      vt[1] = '{seed: 16'h0000, strm: 15'd1, w0: 8'h00, w1: 8'h00, w2: 8'h45};
      vt[2] = '{seed: 16'h5852, strm: 15'd0, w0: 8'h35, w1: 8'h83, w2: 8'h8F};
      vt[3] = '{seed: 16'h0001, strm: 15'd0, w0: 8'h00, w1: 8'h35, w2: 8'h83};

      rst = 1'b1;
      b8.enable = 1'b1; b8.stream = '0; b8.seed_valid = 1'b1; b8.seed = 16'hBEEF;
      b8.out_ready = 1'b0;
      b32.enable = 1'b0; b32.stream = '0; b32.seed_valid = 1'b0; b32.seed = '0;
      b32.out_ready = 1'b1;
      tick();
      tick();
      check("rst_valid", 64'(b8.out_valid), 64'd0);
      check("rst_data", 64'(b8.out_data), 64'd0);
      check("rst_valid32", 64'(b32.out_valid), 64'd0);
      rst = 1'b0;
      b8.seed_valid = 1'b0; b8.enable = 1'b0;

      for (int i = 0; i < 4; i++) apply_vec(vt[i]);

      // Scoreboarded run with a 5-cycle stall, then a reseed after the words.
      b8.seed = 16'h0000; b8.stream = '0; b8.seed_valid = 1'b1;
      b8.enable = 1'b1; b8.out_ready = 1'b1;
      fill8(16'h0000, 16'h0001, 30);
      tick();
      b8.seed_valid = 1'b0;
      run8(30, 8, 5);
      apply_vec(vt[0]);

      // Reset in the middle of a stalled stream.
      b8.out_ready = 1'b0;
      tick(); tick(); tick();
      check("pre_rst_valid", 64'(b8.out_valid), 64'd1);
      rst = 1'b1;
      tick();
      check("mid_rst_valid", 64'(b8.out_valid), 64'd0);
      check("mid_rst_data", 64'(b8.out_data), 64'd0);
      rst = 1'b0; b8.out_ready = 1'b1; b8.enable = 1'b1;
      tick();
      check("post_rst_c1", 64'(b8.out_valid), 64'd0);
      tick();
      check("post_rst_valid", 64'(b8.out_valid), 64'd1);
      check("post_rst_w0", 64'(b8.out_data), 64'h00);
      tick();
      check("post_rst_w1", 64'(b8.out_data), 64'h00);
      tick();
      check("post_rst_w2", 64'(b8.out_data), 64'h35);

      b8.enable = 1'b0;
      tick();
      check("en_low_drain", 64'(b8.out_valid), 64'd1);
      tick();
      check("en_low_idle", 64'(b8.out_valid), 64'd0);

      // pcg32 configuration: steady acceptance, then random back-pressure.
      b32.seed = 64'h0; b32.stream = '0; b32.seed_valid = 1'b1;
      b32.enable = 1'b1; b32.out_ready = 1'b1;
      fill32(64'h0, 64'h1, 1000);
      tick();
      b32.seed_valid = 1'b0;
      run32(1000, 1'b0);

      b32.seed_valid = 1'b1; b32.out_ready = 1'b1;
      fill32(64'h0, 64'h1, 1000);
      tick();
      b32.seed_valid = 1'b0;
      run32(1000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
